// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encoding,
// the HALT opcode and the position of the opcode field in a 32-bit word.
package ifu_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_ISSUE  = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   localparam int OPC_W   = 6;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;

   localparam logic [OPC_W-1:0] OPC_HALT = 6'b111111;

endpackage

// File: rtl/ifu_pc_counter.sv
// Program counter register for the fetch unit.
// Ports: clk, rst (async, active-high), load_en/load_val (branch load,
// priority over inc_en), inc_en (pc+1, wraps modulo 2^ADDR_W), pc (current PC).
module ifu_pc_counter #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load_en) begin
         pc <= load_val;
      end else if (inc_en) begin
         pc <= pc + ONE;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: fetches words over mem_req/mem_ack,
// issues them to the CU over instr_valid/cu_ready, updates the PC and
// stops on the HALT opcode.
// Ports: clk, rst (async, active-high); mem_req/mem_addr/mem_ack/mem_rdata
// (instruction memory); opCode/instr/instr_valid/cu_ready (CU issue);
// branch_en/branch_target (sampled at issue handshake); pc, halt, fault.
// Optional feature: define IFU_TIMEOUT_EN to build the fetch timeout
// (fault + halt after TMO_CYC ack-wait cycles); otherwise fault is 0.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TMO_CYC  = 15
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [OPC_W-1:0]   opCode,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               cu_ready,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  pc,
   output logic               halt,
   output logic               fault
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [INSTR_W-1:0] instr_q;
   logic               in_fetch;
   logic               hs;
   logic               is_halt;
   logic               tmo_hit;

   assign in_fetch    = (state == ST_FETCH);
   assign hs          = (state == ST_ISSUE) & cu_ready;
   assign is_halt     = (opCode == OPC_HALT);

   assign mem_req     = in_fetch;
   assign mem_addr    = pc;
   assign instr_valid = (state == ST_ISSUE);
   assign halt        = (state == ST_HALTED);
   assign instr       = instr_q;
   assign opCode      = instr_q[INSTR_W-1 -: OPC_W];

   ifu_pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load_en  (hs & ~is_halt & branch_en),
      .load_val (branch_target),
      .inc_en   (hs & ~is_halt & ~branch_en),
      .pc       (pc)
   );

`ifdef IFU_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             fault_q;

   // Fires in the TMO_CYC-th consecutive FETCH cycle without an ack.
   assign tmo_hit = in_fetch & ~mem_ack &
                    (tmo_cnt == TMO_W'(TMO_CYC - 1));
   assign fault   = fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         fault_q <= 1'b0;
      end else begin
         if (in_fetch & ~mem_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
         if (tmo_hit) begin
            fault_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign fault   = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ack) begin
               state_nxt = ST_ISSUE;
            end else if (tmo_hit) begin
               state_nxt = ST_HALTED;
            end
         end
         ST_ISSUE: begin
            if (cu_ready) begin
               state_nxt = is_halt ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Only an ack while fetching may load the instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
      end else if (in_fetch & mem_ack) begin
         instr_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scenario tasks with randomized
// memory latency, CU stalls and branches against a PC/memory reference model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [5:0]  opCode;
   logic [31:0] instr;
   logic        instr_valid;
   logic        cu_ready;
   logic        branch_en;
   logic [7:0]  branch_target;
   logic [7:0]  pc;
   logic        halt;
   logic        fault;

   logic [31:0] mem [256];
   logic [7:0]  m_pc;
   int          n_cmp = 0;
   int          n_mis = 0;

   instr_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .opCode        (opCode),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .cu_ready      (cu_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .pc            (pc),
      .halt          (halt),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch + issue, starting in a cycle where a fetch is expected.
   task automatic issue_one(input int ad, input int rd, input bit br,
                            input logic [7:0] tgt, output int cyc);
      logic [31:0] word;
      cyc  = 0;
      word = mem[m_pc];
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
         n_mis++;
         $display("FAIL fetch_req: req=%b addr=%h required 1/%h",
                  mem_req, mem_addr, m_pc);
      end
      for (int i = 0; i < ad; i++) begin
         mem_ack       = 1'b0;
         branch_en     = 1'($urandom % 2);
         branch_target = 8'($urandom);
         tick();
         cyc++;
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== m_pc ||
             instr_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL fetch_wait: req=%b addr=%h vld=%b required 1/%h/0",
                     mem_req, mem_addr, instr_valid, m_pc);
         end
      end
      mem_ack   = 1'b1;
      mem_rdata = word;
      branch_en = 1'($urandom % 2);
      tick();
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== word ||
          opCode !== word[31:26] || mem_req !== 1'b0) begin
         n_mis++;
         $display("FAIL issue: vld=%b instr=%h opc=%h req=%b required 1/%h/%h/0",
                  instr_valid, instr, opCode, mem_req, word, word[31:26]);
      end
      for (int i = 0; i < rd; i++) begin
         cu_ready      = 1'b0;
         mem_ack       = 1'($urandom % 2);
         mem_rdata     = $urandom;
         branch_en     = 1'($urandom % 2);
         branch_target = 8'($urandom);
         tick();
         cyc++;
         n_cmp++;
         if (instr_valid !== 1'b1 || instr !== word ||
             mem_req !== 1'b0 || pc !== m_pc) begin
            n_mis++;
            $display("FAIL stall: vld=%b instr=%h req=%b pc=%h required 1/%h/0/%h",
                     instr_valid, instr, mem_req, pc, word, m_pc);
         end
      end
      mem_ack       = 1'b0;
      cu_ready      = 1'b1;
      branch_en     = br;
      branch_target = tgt;
      tick();
      cyc++;
      cu_ready  = 1'b0;
      branch_en = 1'b0;
      if (word[31:26] == 6'h3F) begin
         n_cmp++;
         if (halt !== 1'b1 || mem_req !== 1'b0 ||
             instr_valid !== 1'b0 || pc !== m_pc) begin
            n_mis++;
            $display("FAIL halt_hs: halt=%b req=%b vld=%b pc=%h required 1/0/0/%h",
                     halt, mem_req, instr_valid, pc, m_pc);
         end
      end else begin
         m_pc = br ? tgt : m_pc + 8'd1;
         n_cmp++;
         if (mem_req !== 1'b1 || pc !== m_pc ||
             mem_addr !== m_pc || halt !== 1'b0) begin
            n_mis++;
            $display("FAIL next_pc: req=%b pc=%h halt=%b required 1/%h/0",
                     mem_req, pc, halt, m_pc);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      cu_ready = 1'b0;
      branch_en = 1'b0;
      branch_target = '0;
      repeat (2) tick();
      n_cmp++;
      if (pc !== 8'h00 || mem_req !== 1'b0 || instr_valid !== 1'b0 ||
          halt !== 1'b0 || fault !== 1'b0 || opCode !== 6'h0 ||
          instr !== 32'h0) begin
         n_mis++;
         $display("FAIL reset: pc=%h req=%b vld=%b halt=%b fault=%b opc=%h instr=%h required all 0",
                  pc, mem_req, instr_valid, halt, fault, opCode, instr);
      end
      rst = 1'b0;
      m_pc = 8'h00;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_mis++;
         $display("FAIL idle: req=%b required 0", mem_req);
      end
      tick();
   endtask

   task automatic test_stream();
      int c;
      int total = 0;
      for (int i = 0; i < 3; i++) begin
         issue_one(0, 0, 1'b0, 8'h00, c);
         total += c;
      end
      n_cmp++;
      if (total !== 6) begin
         n_mis++;
         $display("FAIL throughput: cycles=%0d required 6", total);
      end
   endtask

   task automatic test_ack_delay();
      int c;
      issue_one(3, 0, 1'b0, 8'h00, c);
      n_cmp++;
      if (c !== 5) begin
         n_mis++;
         $display("FAIL ack_delay: cycles=%0d required 5", c);
      end
   endtask

   task automatic test_ready_stall();
      int c;
      issue_one(0, 5, 1'b0, 8'h00, c);
   endtask

   task automatic test_branch();
      int c;
      issue_one(1, 1, 1'b1, 8'h40, c);
      n_cmp++;
      if (mem_addr !== 8'h40) begin
         n_mis++;
         $display("FAIL branch: addr=%h required 40", mem_addr);
      end
      issue_one(2, 0, 1'b0, 8'h00, c);
   endtask

   task automatic test_wrap_halt();
      int c;
      issue_one(0, 0, 1'b1, 8'hFF, c);
      issue_one(0, 0, 1'b0, 8'h00, c);
      n_cmp++;
      if (pc !== 8'h00) begin
         n_mis++;
         $display("FAIL wrap: pc=%h required 00", pc);
      end
      mem[8'h20] = 32'hFC000000;
      issue_one(0, 0, 1'b1, 8'h20, c);
      issue_one(1, 2, 1'b1, 8'h55, c);
      for (int i = 0; i < 3; i++) begin
         mem_ack  = 1'($urandom % 2);
         cu_ready = 1'($urandom % 2);
         tick();
         n_cmp++;
         if (halt !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h20) begin
            n_mis++;
            $display("FAIL halted: halt=%b req=%b pc=%h required 1/0/20",
                     halt, mem_req, pc);
         end
      end
      mem_ack  = 1'b0;
      cu_ready = 1'b0;
      mem[8'h20] = 32'h04000020;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (halt !== 1'b0 || pc !== 8'h00) begin
         n_mis++;
         $display("FAIL rst_pulse: halt=%b pc=%h required 0/00", halt, pc);
      end
      tick();
      rst = 1'b0;
      m_pc = 8'h00;
      tick();
      issue_one(0, 0, 1'b1, 8'h90, c);
      rst = 1'b1;
      #2;
      n_cmp++;
      if (mem_req !== 1'b0 || pc !== 8'h00) begin
         n_mis++;
         $display("FAIL rst_mid: req=%b pc=%h required 0/00", mem_req, pc);
      end
      tick();
      rst = 1'b0;
      m_pc = 8'h00;
      tick();
      issue_one(0, 0, 1'b0, 8'h00, c);
   endtask

   task automatic test_random();
      int c;
      for (int i = 0; i < 40; i++) begin
         issue_one($urandom_range(0, 4), $urandom_range(0, 3),
                   1'($urandom % 4 == 0), 8'($urandom), c);
      end
   endtask

   task automatic test_timeout();
      mem_ack = 1'b0;
`ifdef IFU_TIMEOUT_EN
      repeat (14) tick();
      n_cmp++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin
         n_mis++;
         $display("FAIL tmo_early: req=%b fault=%b required 1/0", mem_req, fault);
      end
      tick();
      n_cmp++;
      if (fault !== 1'b1 || halt !== 1'b1 || mem_req !== 1'b0) begin
         n_mis++;
         $display("FAIL tmo: fault=%b halt=%b req=%b required 1/1/0",
                  fault, halt, mem_req);
      end
      repeat (3) tick();
      n_cmp++;
      if (fault !== 1'b1) begin
         n_mis++;
         $display("FAIL tmo_sticky: fault=%b required 1", fault);
      end
`else
      repeat (20) tick();
      n_cmp++;
      if (mem_req !== 1'b1 || fault !== 1'b0 || mem_addr !== m_pc) begin
         n_mis++;
         $display("FAIL no_tmo: req=%b fault=%b addr=%h required 1/0/%h",
                  mem_req, fault, mem_addr, m_pc);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (mem[i][31:26] == 6'h3F) begin
            mem[i][31] = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         mem[i] = {6'(i + 1), 26'($urandom)};
      end
      test_reset();
      test_stream();
      test_ack_delay();
      test_ready_stall();
      test_branch();
      test_wrap_halt();
      test_random();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
